// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if -- instruction-side Wishbone-style bus between the fetch unit
// (master) and instruction memory (slave).
//
// Signals:
//   iwbm_addr_o  32  word-aligned fetch address        (master -> slave)
//   iwbm_cyc_o    1  bus cycle active                  (master -> slave)
//   iwbm_stb_o    1  strobe, mirrors iwbm_cyc_o        (master -> slave)
//   iwbm_dat_i   32  read data, valid with ack         (slave -> master)
//   iwbm_ack_i    1  cycle completed successfully      (slave -> master)
//   iwbm_err_i    1  cycle terminated with bus error   (slave -> master)
// ---------------------------------------------------------------------------
interface fetch_if;
    logic [31:0] iwbm_addr_o;
    logic        iwbm_cyc_o;
    logic        iwbm_stb_o;
    logic [31:0] iwbm_dat_i;
    logic        iwbm_ack_i;
    logic        iwbm_err_i;

    modport master (
        output iwbm_addr_o,
        output iwbm_cyc_o,
        output iwbm_stb_o,
        input  iwbm_dat_i,
        input  iwbm_ack_i,
        input  iwbm_err_i
    );

    modport slave (
        input  iwbm_addr_o,
        input  iwbm_cyc_o,
        input  iwbm_stb_o,
        output iwbm_dat_i,
        output iwbm_ack_i,
        output iwbm_err_i
    );
endinterface

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- single-outstanding instruction fetch unit.
//
// Issues one bus read at a time at the current pc, presents the returned
// instruction (or a fault entry) to the decoder with a valid/ready handshake,
// and handles control-flow redirects, including killing an in-flight bus
// cycle whose data is no longer wanted.
//
// Ports:
//   clk_i                     system clock, rising edge
//   rst_ni                    asynchronous active-low reset
//   iwbm                      instruction bus (fetch_if.master)
//   redirect_i/redirect_pc_i  control-flow change and its target
//   instruction_o/pc_o        fetched instruction and its address
//   valid_o/ready_i           output entry handshake
//   e_inst_access_fault_o     entry is a bus-error fault
//   e_inst_addr_misaligned_o  entry is a misaligned-target fault
// ---------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    fetch_if.master     iwbm,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        e_inst_access_fault_o,
    output logic        e_inst_addr_misaligned_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_state,     w_stateNext;
    logic [31:0] r_pc,        w_pcNext;
    logic [31:0] r_busAddr,   w_busAddrNext;
    logic [31:0] r_instr,     w_instrNext;
    logic [31:0] r_pcOut,     w_pcOutNext;
    logic        r_valid,     w_validNext;
    logic        r_fault,     w_faultNext;
    logic        r_misal,     w_misalNext;
    logic        r_pendMisal, w_pendMisalNext;
    logic        r_live;

    logic        w_cyc;
    logic        w_term;
    logic        w_open;

    // r_live keeps the bus quiet until the first clock edge after reset
    // release, so an ack arriving in that window cannot be mistaken for a
    // response to a cycle this unit never opened.
    assign w_cyc  = r_live && ((r_state == S_REQ) || (r_state == S_KILL));
    assign w_term = w_cyc && (iwbm.iwbm_ack_i || iwbm.iwbm_err_i);
    assign w_open = w_cyc && !w_term;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_ADDR;
            r_busAddr   <= RESET_ADDR;
            r_instr     <= 32'h0;
            r_pcOut     <= 32'h0;
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
            r_misal     <= 1'b0;
            r_pendMisal <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_busAddr   <= w_busAddrNext;
            r_instr     <= w_instrNext;
            r_pcOut     <= w_pcOutNext;
            r_valid     <= w_validNext;
            r_fault     <= w_faultNext;
            r_misal     <= w_misalNext;
            r_pendMisal <= w_pendMisalNext;
            r_live      <= 1'b1;
        end
    end

    // Next-state logic. A redirect overrides everything else; a misaligned
    // target becomes a fault entry, deferred via r_pendMisal if a bus cycle
    // still has to be drained in S_KILL first.
    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_instrNext     = r_instr;
        w_pcOutNext     = r_pcOut;
        w_validNext     = r_valid;
        w_faultNext     = r_fault;
        w_misalNext     = r_misal;
        w_pendMisalNext = r_pendMisal;

        if (redirect_i) begin
            w_pcNext    = redirect_pc_i;
            w_validNext = 1'b0;
            w_faultNext = 1'b0;
            w_misalNext = 1'b0;
            if (redirect_pc_i[1:0] == 2'b00) begin
                w_pendMisalNext = 1'b0;
                w_stateNext     = w_open ? S_KILL : S_REQ;
            end else if (w_open) begin
                w_pendMisalNext = 1'b1;
                w_stateNext     = S_KILL;
            end else begin
                w_pendMisalNext = 1'b0;
                w_validNext     = 1'b1;
                w_misalNext     = 1'b1;
                w_pcOutNext     = redirect_pc_i;
                w_instrNext     = NOP;
                w_stateNext     = S_FAULT;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_cyc && iwbm.iwbm_ack_i) begin
                        w_instrNext = iwbm.iwbm_dat_i;
                        w_pcOutNext = r_pc;
                        w_validNext = 1'b1;
                        w_faultNext = 1'b0;
                        w_misalNext = 1'b0;
                        w_pcNext    = r_pc + 32'd4;
                        w_stateNext = S_HOLD;
                    end else if (w_cyc && iwbm.iwbm_err_i) begin
                        w_instrNext = NOP;
                        w_pcOutNext = r_pc;
                        w_validNext = 1'b1;
                        w_faultNext = 1'b1;
                        w_misalNext = 1'b0;
                        w_stateNext = S_FAULT;
                    end
                end
                S_HOLD: begin
                    if (ready_i) begin
                        w_validNext = 1'b0;
                        w_faultNext = 1'b0;
                        w_misalNext = 1'b0;
                        w_stateNext = S_REQ;
                    end
                end
                S_FAULT: begin
                    if (ready_i) begin
                        w_validNext = 1'b0;
                        w_faultNext = 1'b0;
                        w_misalNext = 1'b0;
                    end
                end
                S_KILL: begin
                    if (w_term) begin
                        w_pendMisalNext = 1'b0;
                        if (r_pendMisal) begin
                            w_validNext = 1'b1;
                            w_misalNext = 1'b1;
                            w_faultNext = 1'b0;
                            w_pcOutNext = r_pc;
                            w_instrNext = NOP;
                            w_stateNext = S_FAULT;
                        end else begin
                            w_stateNext = S_REQ;
                        end
                    end
                end
                default: w_stateNext = S_REQ;
            endcase
        end

        // The bus address freezes while a cycle is open (including one being
        // killed) and otherwise tracks the pc the next cycle will use.
        w_busAddrNext = w_open ? r_busAddr : w_pcNext;
    end

    assign iwbm.iwbm_cyc_o       = w_cyc;
    assign iwbm.iwbm_stb_o       = w_cyc;
    assign iwbm.iwbm_addr_o      = r_busAddr;
    assign instruction_o         = r_instr;
    assign pc_o                  = r_pcOut;
    assign valid_o               = r_valid;
    assign e_inst_access_fault_o    = r_fault;
    assign e_inst_addr_misaligned_o = r_misal;

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch -- self-checking bench for fetch. Expected decoder entries are
// pushed to a scoreboard when the bus response is driven and popped when
// the fetch unit presents them.
// ---------------------------------------------------------------------------
module tb_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
        logic        misal;
    } entry_t;

    logic        clk_i;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        e_inst_access_fault_o;
    logic        e_inst_addr_misaligned_o;

    int compared;
    int mismatched;
    entry_t sb[$];

    fetch_if bus();

    fetch #(.RESET_ADDR(32'h8000_0000)) dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .iwbm                     (bus.master),
        .redirect_i               (redirect_i),
        .redirect_pc_i            (redirect_pc_i),
        .instruction_o            (instruction_o),
        .pc_o                     (pc_o),
        .valid_o                  (valid_o),
        .ready_i                  (ready_i),
        .e_inst_access_fault_o    (e_inst_access_fault_o),
        .e_inst_addr_misaligned_o (e_inst_addr_misaligned_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the DUT to open a bus cycle.
    task automatic waitCyc();
        int n;
        n = 0;
        while (bus.iwbm_cyc_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (bus.iwbm_cyc_o !== 1'b1) checkOutput("cycTimeout", {31'b0, bus.iwbm_cyc_o}, 32'd1);
    endtask

    // Bus slave: waits for a cycle, inserts wait states, then acks or errs.
    task automatic applyStimulus(input int ws, input logic [31:0] dat, input bit err,
                                 input logic [31:0] expAddr);
        entry_t e;
        waitCyc();
        checkOutput("busAddr", bus.iwbm_addr_o, expAddr);
        for (int i = 0; i < ws; i++) begin
            @(negedge clk_i);
            checkOutput("waitCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
            checkOutput("waitAddr", bus.iwbm_addr_o, expAddr);
        end
        if (err) begin
            bus.iwbm_err_i = 1'b1;
            e = '{instr: 32'h0000_0013, pc: expAddr, fault: 1'b1, misal: 1'b0};
        end else begin
            bus.iwbm_ack_i = 1'b1;
            bus.iwbm_dat_i = dat;
            e = '{instr: dat, pc: expAddr, fault: 1'b0, misal: 1'b0};
        end
        sb.push_back(e);
        @(negedge clk_i);
        bus.iwbm_ack_i = 1'b0;
        bus.iwbm_err_i = 1'b0;
        checkOutput("ackLatency", {31'b0, valid_o}, 32'd1);
    endtask

    // Decoder side: compares the presented entry with the scoreboard, holds
    // it for `hold` cycles, then accepts and checks what the bus does next.
    task automatic takeEntry(input int hold, input bit expectBus, input logic [31:0] nextAddr);
        entry_t e;
        logic [31:0] instr0, pc0;
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("validSeen", {31'b0, valid_o}, 32'd1);
        if (sb.size() == 0) begin
            checkOutput("sbEmpty", sb.size(), 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("instr", instruction_o, e.instr);
            checkOutput("pc", pc_o, e.pc);
            checkOutput("fault", {31'b0, e_inst_access_fault_o}, {31'b0, e.fault});
            checkOutput("misal", {31'b0, e_inst_addr_misaligned_o}, {31'b0, e.misal});
        end
        instr0 = instruction_o;
        pc0 = pc_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            checkOutput("holdInstr", instruction_o, instr0);
            checkOutput("holdPc", pc_o, pc0);
            checkOutput("holdCyc", {31'b0, bus.iwbm_cyc_o}, 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        checkOutput("validClr", {31'b0, valid_o}, 32'd0);
        checkOutput("flagsClr", {30'b0, e_inst_access_fault_o, e_inst_addr_misaligned_o}, 32'd0);
        if (expectBus) begin
            checkOutput("nextCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
            checkOutput("nextAddr", bus.iwbm_addr_o, nextAddr);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("haltCyc", {31'b0, bus.iwbm_cyc_o}, 32'd0);
                @(negedge clk_i);
            end
        end
    endtask

    task automatic doRedirect(input logic [31:0] target);
        redirect_i = 1'b1;
        redirect_pc_i = target;
        @(negedge clk_i);
        redirect_i = 1'b0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst_ni = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        ready_i = 1'b0;
        bus.iwbm_dat_i = 32'h0;
        bus.iwbm_ack_i = 1'b0;
        bus.iwbm_err_i = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        checkOutput("rstCyc", {31'b0, bus.iwbm_cyc_o}, 32'd0);
        checkOutput("rstStb", {31'b0, bus.iwbm_stb_o}, 32'd0);
        checkOutput("rstValid", {31'b0, valid_o}, 32'd0);
        checkOutput("rstInstr", instruction_o, 32'h0);
        checkOutput("rstPc", pc_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // First fetch with two wait states, immediate accept.
        applyStimulus(2, 32'h0010_0093, 1'b0, 32'h8000_0000);
        takeEntry(0, 1'b1, 32'h8000_0004);

        // Decoder stalls five cycles.
        applyStimulus(0, 32'h0020_0113, 1'b0, 32'h8000_0004);
        takeEntry(5, 1'b1, 32'h8000_0008);

        // Redirect during a waited cycle: cycle drains, data dropped.
        waitCyc();
        checkOutput("killAddr0", bus.iwbm_addr_o, 32'h8000_0008);
        @(negedge clk_i);
        doRedirect(32'h8000_0100);
        checkOutput("killCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
        checkOutput("killAddr", bus.iwbm_addr_o, 32'h8000_0008);
        @(negedge clk_i);
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        bus.iwbm_ack_i = 1'b0;
        checkOutput("killValid", {31'b0, valid_o}, 32'd0);
        checkOutput("killNextCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
        checkOutput("killNextAddr", bus.iwbm_addr_o, 32'h8000_0100);

        applyStimulus(0, 32'h0030_0193, 1'b0, 32'h8000_0100);
        takeEntry(0, 1'b1, 32'h8000_0104);

        // Redirect and ack in the same cycle: ack data dropped.
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'hBAD0_BAD0;
        doRedirect(32'h8000_0010);
        bus.iwbm_ack_i = 1'b0;
        checkOutput("redAckValid", {31'b0, valid_o}, 32'd0);
        checkOutput("redAckAddr", bus.iwbm_addr_o, 32'h8000_0010);

        // Bus error halts fetch until a redirect.
        applyStimulus(1, 32'h0, 1'b1, 32'h8000_0010);
        takeEntry(2, 1'b0, 32'h0);
        doRedirect(32'h8000_0200);
        checkOutput("resumeCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
        checkOutput("resumeAddr", bus.iwbm_addr_o, 32'h8000_0200);

        // Misaligned redirect while an entry is held: entry replaced by fault.
        applyStimulus(0, 32'h0040_0213, 1'b0, 32'h8000_0200);
        sb.delete();
        sb.push_back('{instr: 32'h0000_0013, pc: 32'h8000_0102, fault: 1'b0, misal: 1'b1});
        doRedirect(32'h8000_0102);
        checkOutput("misalCyc", {31'b0, bus.iwbm_cyc_o}, 32'd0);
        takeEntry(2, 1'b0, 32'h0);

        // Address wrap at the top of memory.
        doRedirect(32'hFFFF_FFFC);
        applyStimulus(0, 32'h0050_0293, 1'b0, 32'hFFFF_FFFC);
        takeEntry(0, 1'b1, 32'h0000_0000);
        applyStimulus(0, 32'h0060_0313, 1'b0, 32'h0000_0000);
        takeEntry(1, 1'b1, 32'h0000_0004);

        // Misaligned redirect during an open cycle: fault after the drain.
        waitCyc();
        doRedirect(32'h0000_0203);
        checkOutput("mkValid", {31'b0, valid_o}, 32'd0);
        checkOutput("mkCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
        checkOutput("mkAddr", bus.iwbm_addr_o, 32'h0000_0004);
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'h1234_5678;
        sb.push_back('{instr: 32'h0000_0013, pc: 32'h0000_0203, fault: 1'b0, misal: 1'b1});
        @(negedge clk_i);
        bus.iwbm_ack_i = 1'b0;
        takeEntry(0, 1'b0, 32'h0);

        // Reset mid-cycle: a late ack must be ignored.
        doRedirect(32'h0000_0100);
        checkOutput("preRstCyc", {31'b0, bus.iwbm_cyc_o}, 32'd1);
        rst_ni = 1'b0;
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'hFFFF_0000;
        #1;
        checkOutput("midRstCyc", {31'b0, bus.iwbm_cyc_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        bus.iwbm_ack_i = 1'b0;
        checkOutput("lateAckValid", {31'b0, valid_o}, 32'd0);
        checkOutput("postRstAddr", bus.iwbm_addr_o, 32'h8000_0000);
        applyStimulus(1, 32'h0070_0393, 1'b0, 32'h8000_0000);
        takeEntry(0, 1'b1, 32'h8000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
